fe_asic_responder: RTL and testbench

- Behavioural and synthesizable emulation of one tracker front-end ASIC's slow-control port.
- It is the responder end of the serial command and readback protocol driven by the front-end board's reset/reload logic.
- Decodes commands arriving on the shared Cmd line and holds the threshold DAC, configuration, data-mask and trigger-mask registers.
- Answers read commands by serializing the register onto its private Data line; used on the emulator board and in tracker benches.

---
 rtl/fe_asic_pkg.sv | 40 ++++
 rtl/fe_asic_cmd_rx.sv | 71 +++++++
 rtl/fe_asic_responder.sv | 144 ++++++++++++++
 tb/tb_fe_asic_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fe_asic_pkg.sv
// Shared constants and types for the front-end ASIC slow-control responder:
// command/response codes, frame lengths and the command decoder state.
package fe_asic_pkg;

  localparam logic [3:0] C_RESET   = 4'b0001;
  localparam logic [3:0] C_RD_THR  = 4'b0100;
  localparam logic [3:0] C_RD_CONF = 4'b0101;
  localparam logic [3:0] C_RD_DMSK = 4'b0110;
  localparam logic [3:0] C_RD_TMSK = 4'b0111;
  localparam logic [3:0] C_LD_THR  = 4'b1010;
  localparam logic [3:0] C_LD_CONF = 4'b1011;
  localparam logic [3:0] C_LD_DMSK = 4'b1100;
  localparam logic [3:0] C_LD_TMSK = 4'b1101;

  localparam logic [2:0] R_THR  = 3'b010;
  localparam logic [2:0] R_CONF = 3'b011;
  localparam logic [2:0] R_DMSK = 3'b100;
  localparam logic [2:0] R_TMSK = 3'b101;

  localparam int THR_LEN  = 8;
  localparam int CONF_LEN = 19;
  localparam int MSK_LEN  = 64;
  localparam int HDR_LEN  = 10;
  localparam int RESP_LEN = 72;

  localparam logic [4:0] BCAST_ADDR = 5'd31;

  typedef enum logic [1:0] {D_IDLE, D_HDR, D_PAY, D_EXEC} dec_state_t;

  // Reads, reset and illegal codes carry no payload.
  function automatic logic [6:0] pay_len(input logic [3:0] code);
    case (code)
      C_LD_THR:            return 7'(THR_LEN);
      C_LD_CONF:           return 7'(CONF_LEN);
      C_LD_DMSK, C_LD_TMSK: return 7'(MSK_LEN);
      default:             return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/fe_asic_cmd_rx.sv
// Serial command deserializer and decoder FSM; presents each complete frame
// for one cycle (EXEC) with code, address match, parity status and payload.
module fe_asic_cmd_rx
  import fe_asic_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [4:0]  Address,
  input  logic        Cmd,
  output logic        valid,
  output logic [3:0]  code,
  output logic        match,
  output logic        par_ok,
  output logic [63:0] payload
);

  dec_state_t          state;
  logic [6:0]          cnt;
  logic [HDR_LEN-1:0]  hdr;
  logic [HDR_LEN-1:0]  hdr_next;
  logic                par;

  assign hdr_next = {hdr[HDR_LEN-2:0], Cmd};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= D_IDLE;
      cnt     <= '0;
      hdr     <= '0;
      par     <= 1'b0;
      payload <= '0;
    end else begin
      unique case (state)
        D_IDLE: if (Cmd) begin
          state   <= D_HDR;
          cnt     <= 7'(HDR_LEN - 1);
          par     <= 1'b0;
          payload <= '0;
        end
        D_HDR: begin
          hdr <= hdr_next;
          par <= par ^ Cmd;
          if (cnt == 7'd0) begin
            // Frames from other chips are still consumed to their full length.
            if (pay_len(hdr_next[4:1]) == 7'd0) state <= D_EXEC;
            else begin
              state <= D_PAY;
              cnt   <= pay_len(hdr_next[4:1]) - 7'd1;
            end
          end else cnt <= cnt - 7'd1;
        end
        D_PAY: begin
          payload <= {payload[62:0], Cmd};
          par     <= par ^ Cmd;
          if (cnt == 7'd0) state <= D_EXEC;
          else             cnt   <= cnt - 7'd1;
        end
        D_EXEC:  state <= D_IDLE;
        default: state <= D_IDLE;
      endcase
    end
  end

  assign valid  = (state == D_EXEC);
  assign code   = hdr[4:1];
  assign match  = (hdr[9:5] == Address) || (hdr[9:5] == BCAST_ADDR);
  assign par_ok = ~par;

endmodule

// File: rtl/fe_asic_responder.sv
// Front-end ASIC slow-control responder: register file, sticky error bits and
// serial readback FSM. Optional parity enforcement via FE_PARITY_CHECK_EN.
module fe_asic_responder
  import fe_asic_pkg::*;
#(
  parameter int          RESP_DLY = 8,
  parameter logic [7:0]  THR_DEF  = 8'h1F,
  parameter logic [18:0] CONF_DEF = 19'h00000,
  parameter logic [63:0] MSK_DEF  = 64'hFFFF_FFFF_FFFF_FFFF
)(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [4:0]  Address,
  input  logic        Cmd,
  output logic        Data,
  output logic [7:0]  ThrDac,
  output logic [21:0] Config,
  output logic [63:0] DatMsk,
  output logic [63:0] TrgMsk,
  output logic        Busy
);

  typedef enum logic [1:0] {R_IDLE, R_DLY, R_SHIFT} resp_state_t;

  logic        rx_valid, rx_match, rx_par_ok;
  logic [3:0]  rx_code;
  logic [63:0] rx_payload;

  fe_asic_cmd_rx u_cmd_rx (
    .Clock   (Clock),
    .Reset   (Reset),
    .Address (Address),
    .Cmd     (Cmd),
    .valid   (rx_valid),
    .code    (rx_code),
    .match   (rx_match),
    .par_ok  (rx_par_ok),
    .payload (rx_payload)
  );

  logic [2:0]        err;
  logic [18:0]       conf;
  resp_state_t       rstate;
  logic [3:0]        dly_cnt;
  logic [6:0]        bit_cnt;
  logic [RESP_LEN-1:0] sr, rd_frame;
  logic              accept, exec_ok, par_err, is_read, legal, read_go;

  assign accept = rx_valid && rx_match;
`ifdef FE_PARITY_CHECK_EN
  assign exec_ok = accept && rx_par_ok;
  assign par_err = accept && !rx_par_ok;
`else
  logic par_unused;
  assign par_unused = rx_par_ok;
  assign exec_ok    = accept;
  assign par_err    = 1'b0;
`endif

  assign is_read = (rx_code[3:2] == 2'b01);
  assign legal   = is_read || (rx_code == C_RESET) || (rx_code inside {[C_LD_THR:C_LD_TMSK]});
  assign read_go = exec_ok && is_read && (rstate == R_IDLE);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_frame = '0;
    unique case (rx_code)
      C_RD_THR:  rd_frame = {1'b1, 2'b00, R_THR,  ThrDac,      58'd0};
      C_RD_CONF: rd_frame = {1'b1, 2'b00, R_CONF, err, conf,   44'd0};
      C_RD_DMSK: rd_frame = {1'b1, 2'b00, R_DMSK, DatMsk,      2'd0};
      C_RD_TMSK: rd_frame = {1'b1, 2'b00, R_TMSK, TrgMsk,      2'd0};
      default:   rd_frame = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ThrDac <= THR_DEF;
      conf   <= CONF_DEF;
      DatMsk <= MSK_DEF;
      TrgMsk <= MSK_DEF;
      err    <= '0;
    end else begin
      if (par_err)                                    err[2] <= 1'b1;
      if (accept && !legal)                           err[1] <= 1'b1;
      if (exec_ok && is_read && (rstate != R_IDLE))   err[0] <= 1'b1;
      if (exec_ok) begin
        case (rx_code)
          C_RESET: begin
            ThrDac <= THR_DEF;
            conf   <= CONF_DEF;
            DatMsk <= MSK_DEF;
            TrgMsk <= MSK_DEF;
            err    <= '0;
          end
          C_LD_THR:  ThrDac <= rx_payload[7:0];
          C_LD_CONF: conf   <= rx_payload[18:0];
          C_LD_DMSK: DatMsk <= rx_payload;
          C_LD_TMSK: TrgMsk <= rx_payload;
          default: ;
        endcase
      end
    end
  end

  // The frame is snapshotted on acceptance, so later loads do not disturb it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rstate  <= R_IDLE;
      dly_cnt <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: if (read_go) begin
          sr      <= rd_frame;
          bit_cnt <= 7'(RESP_LEN - 1);
          if (RESP_DLY <= 1) rstate <= R_SHIFT;
          else begin
            rstate  <= R_DLY;
            dly_cnt <= 4'(RESP_DLY - 2);
          end
        end
        R_DLY: begin
          if (dly_cnt == 4'd0) rstate  <= R_SHIFT;
          else                 dly_cnt <= dly_cnt - 4'd1;
        end
        R_SHIFT: begin
          if (bit_cnt == 7'd0) rstate <= R_IDLE;
          else begin
            sr      <= {sr[RESP_LEN-2:0], 1'b0};
            bit_cnt <= bit_cnt - 7'd1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign Data   = (rstate == R_SHIFT) && sr[RESP_LEN-1];
  assign Busy   = (rstate != R_IDLE) || read_go;
  assign Config = {err, conf};

endmodule

// File: tb/tb_fe_asic_responder.sv
// Directed self-checking bench for fe_asic_responder (default parameters,
// Address 5); parity expectations follow FE_PARITY_CHECK_EN.
module tb_fe_asic_responder;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [4:0]  Address = 5'd5;
  logic        Cmd = 1'b0;
  logic        Data, Busy;
  logic [7:0]  ThrDac;
  logic [21:0] Config;
  logic [63:0] DatMsk, TrgMsk;

  int total = 0;
  int bad   = 0;

  fe_asic_responder dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Address (Address),
    .Cmd     (Cmd),
    .Data    (Data),
    .ThrDac  (ThrDac),
    .Config  (Config),
    .DatMsk  (DatMsk),
    .TrgMsk  (TrgMsk),
    .Busy    (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      Cmd = 1'b0;
    end
  endtask

  // Drives start bit, A, C, P (optionally inverted) and n payload bits, MSB first.
  task automatic send_frame(input logic [4:0] a, input logic [3:0] c,
                            input logic [63:0] pay, input int n, input bit flip);
    logic       p;
    logic [9:0] hdr;
    p = (^a) ^ (^c) ^ flip;
    for (int i = 0; i < n; i++) p ^= pay[i];
    hdr = {a, c, p};
    @(negedge Clock); Cmd = 1'b1;
    for (int i = 9; i >= 0; i--) begin @(negedge Clock); Cmd = hdr[i]; end
    for (int i = n - 1; i >= 0; i--) begin @(negedge Clock); Cmd = pay[i]; end
  endtask

  // Counts idle cycles to the start bit (bounded), then captures stop_at bits;
  // optionally injects an 11-bit command frame starting at response bit inj_at.
  task automatic read_resp(input int stop_at, input logic [10:0] inj, input int inj_at,
                           output logic [71:0] f, output int gap, output bit busy_ok);
    f = '0; gap = 0; busy_ok = 1'b1;
    @(negedge Clock); Cmd = 1'b0;
    while (Data !== 1'b1 && gap < 40) begin
      busy_ok &= (Busy === 1'b1);
      gap++;
      @(negedge Clock);
    end
    for (int k = 0; k < stop_at; k++) begin
      if (k > 0) @(negedge Clock);
      if (inj_at >= 0 && k >= inj_at && k < inj_at + 11) Cmd = inj[10 - (k - inj_at)];
      else Cmd = 1'b0;
      f[71 - k] = Data;
      busy_ok &= (Busy === 1'b1);
    end
  endtask

  logic [71:0] fr;
  logic [71:0] conf_def_frame;
  logic [10:0] no_inj;
  logic [10:0] rd_thr_frame;
  int          gap, ones;
  bit          bok;

  initial begin
    conf_def_frame = {1'b1, 5'b00011, 3'b000, 19'h00000, 44'd0};
    no_inj         = '0;
    rd_thr_frame   = 11'b1_00101_0100_1;

    // Reset state
    #12;
    check("rst_data",   Data,   1'b0);
    check("rst_busy",   Busy,   1'b0);
    check("rst_thr",    ThrDac, 8'h1F);
    check("rst_config", Config, 22'h000000);
    check("rst_datmsk", DatMsk, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_trgmsk", TrgMsk, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge Clock); Reset = 1'b1;
    idle(3);

    // Broadcast config read: 8 idle cycles, then 1,00011, defaults, zero pad
    send_frame(5'd31, 4'b0101, 64'd0, 0, 1'b0);
    read_resp(72, no_inj, -1, fr, gap, bok);
    check("rdconf_gap",   gap, 8);
    check("rdconf_frame", fr,  conf_def_frame);
    check("rdconf_busy",  bok, 1'b1);
    @(negedge Clock);
    check("rdconf_busy_end", Busy, 1'b0);
    check("rdconf_data_end", Data, 1'b0);

    // Frame for chip 5 seen by chip 6 must be ignored but fully consumed
    Address = 5'd6;
    send_frame(5'd5, 4'b1010, 64'hA5, 8, 1'b0);
    idle(3);
    check("nomatch_thr", ThrDac, 8'h1F);
    Address = 5'd5;

    // Threshold load: takes effect 2 cycles after the last payload bit
    send_frame(5'd5, 4'b1010, 64'hA5, 8, 1'b0);
    idle(1);
    check("ldthr_exec", ThrDac, 8'h1F);
    idle(1);
    check("ldthr_done", ThrDac, 8'hA5);
    idle(2);
    send_frame(5'd5, 4'b0100, 64'd0, 0, 1'b0);
    read_resp(72, no_inj, -1, fr, gap, bok);
    check("rdthr_frame", fr, {1'b1, 5'b00010, 8'hA5, 58'd0});
    check("rdthr_gap",   gap, 8);
    idle(2);

    // Broadcast data-mask load, illegal code, then reset command
    send_frame(5'd31, 4'b1100, 64'h0123_4567_89AB_CDEF, 64, 1'b0);
    idle(2);
    check("lddmsk", DatMsk, 64'h0123_4567_89AB_CDEF);
    send_frame(5'd5, 4'b0000, 64'd0, 0, 1'b0);
    idle(2);
    check("illegal_err", Config[21:19], 3'b010);
    send_frame(5'd31, 4'b0001, 64'd0, 0, 1'b0);
    idle(2);
    check("rstcmd_dmsk", DatMsk, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rstcmd_thr",  ThrDac, 8'h1F);
    check("rstcmd_conf", Config, 22'h000000);

    // Overrun: read threshold injected 20 bits into a config response
    send_frame(5'd5, 4'b0101, 64'd0, 0, 1'b0);
    read_resp(72, rd_thr_frame, 20, fr, gap, bok);
    check("ovr_frame", fr,  conf_def_frame);
    check("ovr_busy",  bok, 1'b1);
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (Data === 1'b1) ones++;
    end
    check("ovr_no_second", ones, 0);
    check("ovr_err",       Config[21:19], 3'b001);
    check("ovr_busy_end",  Busy, 1'b0);

    // Trigger-mask load with inverted parity
    send_frame(5'd5, 4'b1101, 64'hDEAD_BEEF_0000_1234, 64, 1'b1);
    idle(2);
`ifdef FE_PARITY_CHECK_EN
    check("parerr_tmsk", TrgMsk, 64'hFFFF_FFFF_FFFF_FFFF);
    check("parerr_flag", Config[21], 1'b1);
`else
    check("parerr_tmsk", TrgMsk, 64'hDEAD_BEEF_0000_1234);
    check("parerr_flag", Config[21], 1'b0);
`endif

    // Asynchronous reset in the middle of a threshold response
    send_frame(5'd5, 4'b1010, 64'h77, 8, 1'b0);
    idle(2);
    check("ldthr77", ThrDac, 8'h77);
    send_frame(5'd5, 4'b0100, 64'd0, 0, 1'b0);
    read_resp(30, no_inj, -1, fr, gap, bok);
    check("arst_prefix", fr[71:42], {1'b1, 5'b00010, 8'h77, 16'd0});
    #2 Reset = 1'b0;
    #1;
    check("arst_data",   Data,   1'b0);
    check("arst_busy",   Busy,   1'b0);
    check("arst_thr",    ThrDac, 8'h1F);
    check("arst_config", Config, 22'h000000);
    check("arst_trgmsk", TrgMsk, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge Clock); Reset = 1'b1;
    idle(2);
    send_frame(5'd5, 4'b0101, 64'd0, 0, 1'b0);
    read_resp(72, no_inj, -1, fr, gap, bok);
    check("post_rst_frame", fr,  conf_def_frame);
    check("post_rst_gap",   gap, 8);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
